// File: rtl/led_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_arb_pkg : shared types, sizes and round-robin helpers          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package led_arb_pkg;

    localparam int NREQ     = 3;
    localparam int LED_W    = 16;
    localparam int ST_STEPS = 33;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_SELFTEST = 2'd2
    } state_t;

    // Search begins one past the last winner; returns last when nothing is pending.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
        logic       found;
        logic [1:0] idx;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = 2'((32'(last) + 32'(k)) % 32'(NREQ));
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_arb_if : request/data/grant/LED bundle of the LED arbiter      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface led_arb_if;
    import led_arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic [LED_W-1:0] data0;
    logic [LED_W-1:0] data1;
    logic [LED_W-1:0] data2;
    logic [NREQ-1:0]  gnt;
    logic [LED_W-1:0] led;
    logic             tick;
    logic             busy;

    modport master (
        output req, data0, data1, data2,
        input  gnt, led, tick, busy
    );

    modport slave (
        input  req, data0, data1, data2,
        output gnt, led, tick, busy
    );

endinterface
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_tick_gen : free-running prescaler, one-cycle tick per period   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module led_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      tick
);

    localparam int            CW    = $clog2(TICK_DIV);
    localparam logic [CW-1:0] C_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == C_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == C_MAX);

endmodule
`default_nettype wire

// File: rtl/led_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_arbiter : tick-paced round-robin arbiter driving a LED bank;   |
// | optional power-up LED sweep enabled by LED_ARB_SELFTEST_EN.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int HOLD_TICKS = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    led_arb_if.slave   bus
);

`ifdef LED_ARB_SELFTEST_EN
    localparam state_t C_RST_STATE = ST_SELFTEST;
`else
    localparam state_t C_RST_STATE = ST_IDLE;
`endif

    logic             w_tick;
    state_t           r_state, w_state_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [3:0]       r_hold, w_hold_nxt;
    logic [1:0]       r_last, w_last_nxt;
    logic [LED_W-1:0] r_led, w_led_sel;
    logic [1:0]       w_win;
    logic             w_own, w_others, w_hold_done, w_take;
`ifdef LED_ARB_SELFTEST_EN
    logic [5:0]       r_step, w_step_nxt;
`endif

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_win       = rr_pick(bus.req, r_last);
    assign w_own       = |(bus.req & r_gnt);
    assign w_others    = |(bus.req & ~r_gnt);
    assign w_hold_done = (5'(r_hold) + 5'd1) >= 5'(HOLD_TICKS);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_hold_nxt  = r_hold;
        w_last_nxt  = r_last;
        w_take      = 1'b0;
`ifdef LED_ARB_SELFTEST_EN
        w_step_nxt  = r_step;
`endif
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_take = |bus.req;
                end
                ST_GRANT: begin
                    if (!w_own) begin
                        // Owner left: hand over on the same tick, or fall back to idle.
                        if (|bus.req) begin
                            w_take = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_gnt_nxt   = '0;
                            w_hold_nxt  = '0;
                        end
                    end else if (w_hold_done && w_others) begin
                        w_take = 1'b1;
                    end else if (r_hold < 4'(HOLD_TICKS)) begin
                        w_hold_nxt = r_hold + 4'd1;
                    end
                end
`ifdef LED_ARB_SELFTEST_EN
                ST_SELFTEST: begin
                    w_gnt_nxt = '0;
                    if (r_step == 6'(ST_STEPS - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt = r_step + 6'd1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            endcase
            if (w_take) begin
                w_state_nxt = ST_GRANT;
                w_gnt_nxt   = onehot(w_win);
                w_last_nxt  = w_win;
                w_hold_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_RST_STATE;
            r_gnt   <= '0;
            r_hold  <= '0;
            r_last  <= 2'd2;
`ifdef LED_ARB_SELFTEST_EN
            r_step  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_hold  <= w_hold_nxt;
            r_last  <= w_last_nxt;
`ifdef LED_ARB_SELFTEST_EN
            r_step  <= w_step_nxt;
`endif
        end
    end

    always_comb begin
        w_led_sel = '0;
        case (r_gnt)
            3'b001:  w_led_sel = bus.data0;
            3'b010:  w_led_sel = bus.data1;
            3'b100:  w_led_sel = bus.data2;
            default: w_led_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
`ifdef LED_ARB_SELFTEST_EN
            // Sweep fills from the MSB, drains toward the MSB, then blanks.
            if (r_state == ST_SELFTEST) begin
                if (w_tick) begin
                    if (r_step < 6'(LED_W)) begin
                        r_led <= {1'b1, r_led[LED_W-1:1]};
                    end else if (r_step < 6'(2 * LED_W)) begin
                        r_led <= {r_led[LED_W-2:0], 1'b0};
                    end else begin
                        r_led <= '0;
                    end
                end
            end else begin
                r_led <= w_led_sel;
            end
`else
            r_led <= w_led_sel;
`endif
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.led  = r_led;
    assign bus.tick = w_tick;
`ifdef LED_ARB_SELFTEST_EN
    assign bus.busy = (|r_gnt) || (r_state == ST_SELFTEST);
`else
    assign bus.busy = |r_gnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_arbiter : directed scoreboard bench for led_arbiter         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_led_arbiter;

    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 2;

    typedef struct packed {
        logic [2:0]  gnt;
        logic [15:0] led;
        logic        busy;
    } exp_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   sb_q[$];
    string  tag_q[$];

    always #5 clk = ~clk;

    led_arb_if bus ();

    led_arbiter #(
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] pat(input logic [2:0] g);
        case (g)
            3'b001:  pat = bus.data0;
            3'b010:  pat = bus.data1;
            3'b100:  pat = bus.data2;
            default: pat = 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Returns at the falling edge just after the next tick edge.
    task automatic step_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < 32);
        if (!bus.tick) chk("tick_timeout", 32'(bus.tick), 32'd1);
        @(negedge clk);
    endtask

    task automatic grant_step(input string tag, input logic [2:0] eg);
        exp_t  e;
        string t;
        sb_q.push_back('{gnt: eg, led: pat(eg), busy: |eg});
        tag_q.push_back(tag);
        step_tick();
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk({t, "_gnt"},  32'(bus.gnt),  32'(e.gnt));
        chk({t, "_busy"}, 32'(bus.busy), 32'(e.busy));
        @(negedge clk);
        chk({t, "_led"},  32'(bus.led),  32'(e.led));
    endtask

    initial begin
        int          n;
        logic [15:0] ones;
        logic [15:0] exp_led;
        ones      = 16'hFFFF;
        bus.data0 = 16'hA5A5;
        bus.data1 = 16'h5A5A;
        bus.data2 = 16'hC3C3;
`ifdef LED_ARB_SELFTEST_EN
        bus.req   = 3'b111;
`else
        bus.req   = 3'b001;
`endif
        repeat (3) @(negedge clk);
        chk("rst_gnt",  32'(bus.gnt),  32'd0);
        chk("rst_led",  32'(bus.led),  32'd0);
        chk("rst_tick", 32'(bus.tick), 32'd0);
`ifdef LED_ARB_SELFTEST_EN
        chk("rst_busy", 32'(bus.busy), 32'd1);
`else
        chk("rst_busy", 32'(bus.busy), 32'd0);
`endif
        rst_n = 1'b1;

`ifdef LED_ARB_SELFTEST_EN
        for (int k = 1; k <= 33; k++) begin
            exp_led = (k <= 16) ? (ones << (16 - k)) : (ones << (k - 16));
            step_tick();
            chk($sformatf("st%0d_led", k),  32'(bus.led),  32'(exp_led));
            chk($sformatf("st%0d_gnt", k),  32'(bus.gnt),  32'd0);
            chk($sformatf("st%0d_busy", k), 32'(bus.busy), (k < 33) ? 32'd1 : 32'd0);
        end
        grant_step("st_exit_grant", 3'b001);
`else
        grant_step("first_grant", 3'b001);

        bus.req = 3'b011;
        grant_step("rr_hold1", 3'b001);
        grant_step("rr_sw1",   3'b010);
        grant_step("rr_hold2", 3'b010);
        grant_step("rr_sw2",   3'b001);

        bus.data0 = 16'h0F0F;
        @(negedge clk);
        chk("led_follow", 32'(bus.led), 32'h0F0F);

        bus.req = 3'b100;
        grant_step("swap_no_gap", 3'b100);
        bus.req = 3'b000;
        grant_step("release_idle", 3'b000);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < 16);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < 16);
        chk("tick_period", 32'(n), 32'(TICK_DIV));

        // Two-cycle pulse between ticks must not be seen.
        @(negedge clk);
        bus.req = 3'b010;
        @(negedge clk);
        @(negedge clk);
        bus.req = 3'b000;
        grant_step("pulse_ignored", 3'b000);

        bus.req = 3'b010;
        grant_step("grant_before_rst", 3'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt",  32'(bus.gnt),  32'd0);
        chk("async_rst_led",  32'(bus.led),  32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.req = 3'b111;
        rst_n   = 1'b1;
        grant_step("post_rst_first", 3'b001);
        grant_step("rr3_hold0",      3'b001);
        grant_step("rr3_to1",        3'b010);
        grant_step("rr3_hold1",      3'b010);
        grant_step("rr3_to2",        3'b100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per arbitration tick (legal range 2 to 2^27).
REQ-002 Parameter HOLD_TICKS, default 4, minimum ticks a grant is held while its requester stays asserted (legal range 1 to 15).
REQ-003 clk  in  1  system clock, single domain, 100 MHz on board.
REQ-004 rst_n  in  1  asynchronous active-low reset; assertion takes effect immediately, release is sampled on clk.
REQ-005 req  in  3  request lines, bit i from requester i, level-sensitive.
REQ-006 data0, data1, data2  in  16 each  LED pattern offered by requesters 0, 1 and 2.
REQ-007 gnt  out  3  grant, one-hot or all-zero, registered.
REQ-008 led  out  16  LED bank drive, registered.
REQ-009 tick  out  1  one-cycle pulse each arbitration tick.
REQ-010 busy  out  1  high while a grant is active or the self-test runs.

Function
REQ-011 Prescaler shall count 0..TICK_DIV-1 and wrap, asserting tick on the cycle the count equals TICK_DIV-1.
REQ-012 State machine shall have states IDLE, GRANT and SELFTEST, and shall change state, gnt and hold count only on edges where tick=1.
REQ-013 IDLE: on tick, if any req bit is set, go to GRANT and assert the round-robin winner; otherwise stay in IDLE with gnt=000.
REQ-014 Round-robin: search starts at (last_granted+1) mod 3; last_granted updates on every new grant.
REQ-015 GRANT: hold_cnt shall clear on a new grant and increment (saturating at HOLD_TICKS) on each later tick.
REQ-016 GRANT, tick, own req low: release regardless of hold_cnt; grant the next pending requester, else go to IDLE with gnt=000.
REQ-017 GRANT, tick, own req high, hold_cnt+1>=HOLD_TICKS, another requester pending: switch to the round-robin winner; otherwise keep the grant.
REQ-018 req shall be sampled on the tick edge only; pulses between ticks shall be ignored.
REQ-019 led shall load the data word of the currently registered gnt every cycle (1-cycle latency from dataN); led shall load 0x0000 when gnt=000 outside SELFTEST.
REQ-020 busy shall be high when gnt is nonzero or state is SELFTEST.
REQ-021 When a requester drops req and another raises req at the same tick, the tick shall be arbitrated on the sampled values, with no idle gap.

Reset
REQ-022 Reset shall set prescaler=0, tick=0, gnt=000, led=0x0000, hold_cnt=0, last_granted=2 (requester 0 wins first), and state=IDLE or SELFTEST per REQ-024.
REQ-023 Reset asserted mid-grant or mid-self-test shall abort immediately to reset values, with no completion of the step in progress.

Configuration
REQ-024 With LED_ARB_SELFTEST_EN defined, reset exit shall enter SELFTEST; with it undefined, SELFTEST logic shall be absent and reset exit shall enter IDLE.
REQ-025 SELFTEST sequence, one step per tick, req ignored, gnt=000:
- steps 0-15: led={1,led[15:1]}
- steps 16-31: led={led[14:0],0}
- step 32: led=0x0000, then go to IDLE.

Structure
REQ-026 Shared package led_arb_pkg shall hold the state enum, NREQ=3, LED_W=16 and the self-test step count 33.
REQ-027 The prescaler shall be sub-module led_tick_gen (parameter TICK_DIV, outputs tick); all other logic shall be in led_arbiter.

Verification (TICK_DIV=4, HOLD_TICKS=2)
REQ-028 Macro undefined, rst_n released, req=001, data0=0xA5A5 -> gnt=001 at the first tick; led=0xA5A5 one cycle later; busy=1.
REQ-029 req=011 held constant -> gnt alternates 001,010 every 2 ticks (8 cycles); led follows data0/data1 with 1-cycle lag.
REQ-030 gnt=001 at hold_cnt=0, req drops to 100 -> next tick gnt=100 with no IDLE gap; req then 000 -> next tick gnt=000, led=0x0000, busy=0.
REQ-031 Macro defined, reset released -> led=0x8000,0xC000,...,0xFFFF over ticks 1-16, then 0xFFFE...0x0000 over ticks 17-32, step 33 enters IDLE; req=111 meanwhile yields gnt=000 throughout.
REQ-032 rst_n pulsed low mid-grant -> gnt=000 and led=0x0000 asynchronously, before the next clk edge; after release requester 0 wins first.
REQ-033 req bit pulsed high for 2 cycles strictly between ticks -> no grant issued, state stays IDLE.
